// File: rtl/modn_counter_ctrl.sv
// -----------------------------------------------------------------------------
// modn_counter_ctrl
//
// Run-control sequencer for a programmable mod-N count datapath. Downstream
// timing logic uses the wrap/done strobes instead of its own free-running
// mod-N counter.
//
// The modulus and repeat count are loaded through a valid/ready handshake.
// Loads are accepted only while idle or done. The sequencer then handles
// start, pause/resume, abort and completion of the count.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   cfg_valid  configuration offer
//   cfg_ready  configuration accepted this cycle (IDLE or DONE)
//   cfg_n      requested modulus, legal 2..2^WIDTH-1
//   cfg_reps   wraps before DONE, 0 = run continuously
//   cfg_err    one-cycle pulse: offered cfg_n was rejected
//   start      start from IDLE/DONE, resume from HOLD
//   stop       pause from RUN, abort from HOLD (wins over start)
//   en         count enable, effective in RUN only
//   count      current count value
//   wrap       one-cycle pulse when count returns to 0 from N-1
//   done       one-cycle pulse on entry to DONE
//   busy       high in RUN or HOLD
//   state      IDLE=0, RUN=1, HOLD=2, DONE=3
//   wrap_cnt   wraps since the last start, saturating
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | configured, not counting; accepts configuration and start
// RUN    | counting on en; strobes wrap and, on the last repeat, done
// HOLD   | paused with count and remaining wraps frozen; start resumes
// DONE   | repeat count exhausted; count parked at 0, wrap_cnt kept
// -----------------------------------------------------------------------------
module modn_counter_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DEFAULT_N = 10,
  parameter int RW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_n,
  input  logic [RW-1:0]    cfg_reps,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state,
  output logic [RW-1:0]    wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // The modulus register is one bit wider than the count. DEFAULT_N may be
  // 2^WIDTH, which would not fit in WIDTH bits.
  localparam logic [WIDTH:0]   N_RST   = (WIDTH + 1)'(DEFAULT_N);
  localparam logic [WIDTH:0]   ONE_N   = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_N   = WIDTH'(2);
  localparam logic [RW-1:0]    ONE_R   = RW'(1);
  localparam logic [RW-1:0]    ZERO_R  = '0;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH:0]   mod_q,      mod_d;
  logic [RW-1:0]    reps_q,     reps_d;
  logic [RW-1:0]    rem_q,      rem_d;
  logic [RW-1:0]    wrap_cnt_q, wrap_cnt_d;
  logic             wrap_q,     wrap_d;
  logic             done_q,     done_d;
  logic             cfg_err_q,  cfg_err_d;

  logic             cfg_xfer;
  logic             at_last;
  logic [WIDTH:0]   mod_m1;
  logic [RW-1:0]    wrap_cnt_inc;

  assign cfg_ready    = (state_q == IDLE) || (state_q == DONE);
  assign cfg_xfer     = cfg_valid && cfg_ready;
  assign mod_m1       = mod_q - ONE_N;
  assign at_last      = ({1'b0, count_q} == mod_m1);
  assign wrap_cnt_inc = (wrap_cnt_q == '1) ? wrap_cnt_q : wrap_cnt_q + ONE_R;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mod_d      = mod_q;
    reps_d     = reps_q;
    rem_d      = rem_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // A handshake in this cycle takes priority over start. The start
        // request is dropped even when the offer is rejected.
        if (cfg_xfer) begin
          if (cfg_n >= MIN_N) begin
            mod_d   = {1'b0, cfg_n};
            reps_d  = cfg_reps;
            state_d = IDLE;
            count_d = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (start && !stop) begin
          state_d    = RUN;
          count_d    = '0;
          wrap_cnt_d = '0;
          rem_d      = reps_q;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (en) begin
          if (at_last) begin
            count_d    = '0;
            wrap_d     = 1'b1;
            wrap_cnt_d = wrap_cnt_inc;
            if (reps_q != ZERO_R) begin
              rem_d = rem_q - ONE_R;
              if (rem_q == ONE_R) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            count_d = count_q + ONE_C;
          end
        end
      end

      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mod_q      <= N_RST;
      reps_q     <= '0;
      rem_q      <= '0;
      wrap_cnt_q <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mod_q      <= mod_d;
      reps_q     <= reps_d;
      rem_q      <= rem_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign wrap_cnt = wrap_cnt_q;
  assign state    = state_q;
  assign busy     = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_modn_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modn_counter_ctrl
//
// Directed bench for modn_counter_ctrl with the default parameters:
// WIDTH=4, DEFAULT_N=10, RW=8.
//
// Inputs change and outputs are read 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_modn_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int RW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_n;
  logic [RW-1:0]    cfg_reps;
  logic             cfg_err;
  logic             start;
  logic             stop;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             done;
  logic             busy;
  logic [1:0]       state;
  logic [RW-1:0]    wrap_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic done_seen;
  int   m;
  logic expw;

  modn_counter_ctrl #(.WIDTH(WIDTH), .DEFAULT_N(10), .RW(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_n     (cfg_n),
    .cfg_reps  (cfg_reps),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .count     (count),
    .wrap      (wrap),
    .done      (done),
    .busy      (busy),
    .state     (state),
    .wrap_cnt  (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen = 1'b1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_cfg(input logic [WIDTH-1:0] n, input logic [RW-1:0] r);
    cfg_valid = 1'b1;
    cfg_n     = n;
    cfg_reps  = r;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_reps = '0;
    start = 1'b0; stop = 1'b0; en = 1'b0; done_seen = 1'b0;
    #1;
    chk("rst_state",    state,    0);
    chk("rst_count",    count,    0);
    chk("rst_wrap",     wrap,     0);
    chk("rst_done",     done,     0);
    chk("rst_cfg_err",  cfg_err,  0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_busy",     busy,     0);
    chk("rst_cfg_rdy",  cfg_ready, 1);
    step(2);
    reset = 1'b0;
    tick();

    // 1: default N=10, continuous
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_state_run", state, 1);
    chk("t1_count0",    count, 0);
    chk("t1_busy",      busy,  1);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("t1_count", count, i % 10);
      chk("t1_wrap",  wrap,  (i % 10) == 0);
    end
    chk("t1_wrap_cnt", wrap_cnt, 3);
    chk("t1_state",    state,    1);
    chk("t1_no_done",  done_seen, 0);
    stop = 1'b1;
    tick();
    chk("t1_hold", state, 2);
    tick();
    stop = 1'b0;
    chk("t1_abort_idle",  state,    0);
    chk("t1_abort_count", count,    0);
    chk("t1_abort_wcnt",  wrap_cnt, 3);

    // 2: N=5, reps=3 -> DONE after 15 enabled edges
    chk("t2_ready", cfg_ready, 1);
    do_cfg(4'd5, 8'd3);
    chk("t2_cfg_idle", state,   0);
    chk("t2_cfg_err",  cfg_err, 0);
    done_seen = 1'b0;
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_run",     state,    1);
    chk("t2_wcnt0",   wrap_cnt, 0);
    step(14);
    chk("t2_pre_done", done_seen, 0);
    chk("t2_pre_state", state, 1);
    chk("t2_pre_count", count, 4);
    tick();
    chk("t2_done",  done,     1);
    chk("t2_wrap",  wrap,     1);
    chk("t2_state", state,    3);
    chk("t2_count", count,    0);
    chk("t2_wcnt",  wrap_cnt, 3);
    chk("t2_busy",  busy,     0);
    tick();
    chk("t2_done_pulse", done,     0);
    chk("t2_stay_done",  state,    3);
    chk("t2_wcnt_hold",  wrap_cnt, 3);

    // 3: N=5, reps=0, en toggling
    do_cfg(4'd5, 8'd0);
    chk("t3_cfg_idle", state, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    m = 0;
    for (int i = 0; i < 10; i++) begin
      en = (i % 2) == 0;
      tick();
      expw = 1'b0;
      if (en) begin
        m = (m + 1) % 5;
        expw = (m == 0);
      end
      chk("t3_count", count, m);
      chk("t3_wrap",  wrap,  expw);
    end
    chk("t3_wcnt", wrap_cnt, 1);

    // 4: pause/resume, then abort from HOLD
    done_seen = 1'b0;
    en = 1'b1;
    step(3);
    chk("t4_count3", count, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_hold",      state, 2);
    chk("t4_stop_frz",  count, 3);
    step(8);
    chk("t4_hold_cnt",  count, 3);
    chk("t4_hold_st",   state, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_resume", state, 1);
    chk("t4_res_c3", count, 3);
    tick();
    chk("t4_c4", count, 4);
    tick();
    chk("t4_c0",   count, 0);
    chk("t4_wrap", wrap,  1);
    stop = 1'b1;
    tick();
    chk("t4_hold2", state, 2);
    tick();
    stop = 1'b0;
    chk("t4_idle",    state, 0);
    chk("t4_cnt0",    count, 0);
    chk("t4_no_done", done_seen, 0);

    // 5: illegal configuration, busy handshake, start+stop
    do_cfg(4'd10, 8'd0);
    cfg_valid = 1'b1; cfg_n = 4'd1; cfg_reps = 8'd2;
    tick();
    cfg_valid = 1'b0;
    chk("t5_err",       cfg_err, 1);
    chk("t5_err_state", state,   0);
    tick();
    chk("t5_err_pulse", cfg_err, 0);
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    step(9);
    chk("t5_c9",    count, 9);
    chk("t5_nowr",  wrap,  0);
    tick();
    chk("t5_c0",    count, 0);
    chk("t5_wrap",  wrap,  1);
    chk("t5_run",   state, 1);
    cfg_valid = 1'b1; cfg_n = 4'd3; cfg_reps = 8'd1;
    #1;
    chk("t5_rdy_run", cfg_ready, 0);
    tick();
    chk("t5_run_err",   cfg_err, 0);
    chk("t5_run_state", state,   1);
    chk("t5_run_c1",    count,   1);
    step(8);
    cfg_valid = 1'b0;
    chk("t5_mod_kept", count, 9);
    start = 1'b1; stop = 1'b1;
    tick();
    chk("t5_ss_hold", state, 2);
    chk("t5_ss_cnt",  count, 9);
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_ss_idle", state, 0);

    // 6: asynchronous reset mid-RUN
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    step(17);
    chk("t6_c7",   count,    7);
    chk("t6_wcnt", wrap_cnt, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_state", state,    0);
    chk("t6_rst_count", count,    0);
    chk("t6_rst_wcnt",  wrap_cnt, 0);
    chk("t6_rst_busy",  busy,     0);
    chk("t6_rst_done",  done,     0);
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_run", state, 1);
    chk("t6_c0",  count, 0);
    step(9);
    chk("t6_c9",   count, 9);
    tick();
    chk("t6_wrap", wrap,  1);
    chk("t6_cw0",  count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
